axis_ring_writer: RTL and testbench

Streams AXI4-Stream samples into a circular DRAM buffer over an AXI3 write master. It accepts any burst length up to 16 beats, wraps at a run-time buffer size, and limits the number of outstanding write responses. Status outputs expose the write pointer, wrap count, overflow and busy state. It sits between an ADC/DSP stream and the PS HP port; software reads sts_addr and sts_wraps to locate the newest data.

---
 rtl/axis_ring_writer.sv | 175 +++++++++++++++++
 tb/tb_axis_ring_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ring_writer.sv
// rtl/axis_ring_writer.sv - AXI4-Stream to circular DRAM buffer writer over an AXI3 write master
module axis_ring_writer #(
    parameter int ADDR_WIDTH       = 20,
    parameter int AXI_ID_WIDTH     = 6,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH       = 512,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [ADDR_WIDTH-1:0]       cfg_size,
    input  logic                        cfg_enable,
    output logic [ADDR_WIDTH-1:0]       sts_addr,
    output logic [15:0]                 sts_wraps,
    output logic                        sts_overflow,
    output logic                        sts_busy,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [3:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic [3:0]                  m_axi_awcache,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready
);
    localparam int SIZE_LOG = $clog2(AXI_DATA_WIDTH / 8);
    localparam int FIFO_AW  = $clog2(FIFO_DEPTH);
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                      state;
    logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]          wr_idx, rd_idx;
    logic [FIFO_AW:0]            count;
    logic                        full, push, pop;
    logic                        enable_q, enable_rise;
    logic [ADDR_WIDTH-1:0]       pointer, ptr_start, size_eff;
    logic [ADDR_WIDTH:0]         ptr_sum;
    logic                        ptr_wrap;
    logic [4:0]                  beat;
    logic                        aw_done, aw_hs, last_hs, start;
    logic [OUT_W-1:0]            outstanding;
    logic [AXI_ID_WIDTH-1:0]     burst_id;

    assign full          = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign s_axis_tready = ~areset & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axi_wvalid & m_axi_wready;
    assign m_axi_wdata   = mem[rd_idx];

    assign m_axi_awlen   = 4'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'(SIZE_LOG);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = 1'b1;
    assign m_axi_awid    = burst_id;
    assign m_axi_wid     = burst_id;
    assign m_axi_wlast   = m_axi_wvalid && (beat == 5'(BURST_LEN - 1));
    assign sts_busy      = (state != S_IDLE) || (outstanding != '0);

    assign enable_rise = cfg_enable & ~enable_q;
    // A size smaller than one burst would never advance; clamp it to one burst.
    assign size_eff    = (cfg_size < ADDR_WIDTH'(BURST_LEN)) ? ADDR_WIDTH'(BURST_LEN) : cfg_size;
    assign ptr_sum     = {1'b0, pointer} + (ADDR_WIDTH+1)'(BURST_LEN);
    assign ptr_wrap    = (ptr_sum >= {1'b0, size_eff});
    assign ptr_start   = enable_rise ? '0 : pointer;
    assign aw_hs       = m_axi_awvalid & m_axi_awready;
    assign last_hs     = pop & m_axi_wlast;
    assign start       = cfg_enable && (count >= (FIFO_AW+1)'(BURST_LEN))
                         && (outstanding < OUT_W'(MAX_OUTSTANDING));

    always_ff @(posedge aclk) begin
        if (push) mem[wr_idx] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            enable_q      <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            aw_done       <= 1'b0;
            beat          <= '0;
            pointer       <= '0;
            sts_addr      <= '0;
            sts_wraps     <= '0;
            sts_overflow  <= 1'b0;
            outstanding   <= '0;
            burst_id      <= '0;
        end else begin
            enable_q <= cfg_enable;

            if (aw_hs && !m_axi_bvalid)
                outstanding <= outstanding + 1'b1;
            else if (!aw_hs && m_axi_bvalid && outstanding != '0)
                outstanding <= outstanding - 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_axi_awaddr  <= cfg_addr + (AXI_ADDR_WIDTH'(ptr_start) << SIZE_LOG);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        beat          <= '0;
                        state         <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (pop) begin
                        beat <= beat + 1'b1;
                        if (last_hs) begin
                            m_axi_wvalid <= 1'b0;
                            pointer      <= ptr_wrap ? '0 : ptr_sum[ADDR_WIDTH-1:0];
                            sts_addr     <= ptr_wrap ? '0 : ptr_sum[ADDR_WIDTH-1:0];
                            if (ptr_wrap) sts_wraps <= sts_wraps + 1'b1;
                        end else begin
                            sts_addr <= sts_addr + 1'b1;
                        end
                    end
                    // W may finish before AW; leave only once both channels are done.
                    if ((aw_done || aw_hs) && (!m_axi_wvalid || last_hs)) begin
                        state    <= S_IDLE;
                        burst_id <= burst_id + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enable_rise) begin
                pointer      <= '0;
                sts_addr     <= '0;
                sts_wraps    <= '0;
                sts_overflow <= 1'b0;
            end else if (cfg_enable && full && s_axis_tvalid) begin
                sts_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_ring_writer.sv
// tb/tb_axis_ring_writer.sv - directed bench for axis_ring_writer
module tb_axis_ring_writer;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [31:0] cfg_addr, sm_cfg_addr;
    logic [19:0] cfg_size, sm_cfg_size;
    logic        cfg_enable, sm_cfg_enable;
    logic [19:0] sts_addr, sm_sts_addr;
    logic [15:0] sts_wraps, sm_sts_wraps;
    logic        sts_overflow, sm_sts_overflow, sts_busy, sm_sts_busy;
    logic [5:0]  awid, wid, sm_awid, sm_wid;
    logic [31:0] awaddr, sm_awaddr;
    logic [3:0]  awlen, sm_awlen, awcache, sm_awcache;
    logic [2:0]  awsize, sm_awsize;
    logic [1:0]  awburst, sm_awburst;
    logic        awvalid, awready, sm_awvalid, sm_awready;
    logic [63:0] wdata, sm_wdata, s_tdata, sm_tdata;
    logic [7:0]  wstrb, sm_wstrb;
    logic        wlast, wvalid, wready, sm_wlast, sm_wvalid, sm_wready;
    logic        bvalid, bready, sm_bvalid, sm_bready;
    logic        s_tvalid, s_tready, sm_tvalid, sm_tready;

    axis_ring_writer dut (
        .aclk(aclk), .areset(areset), .cfg_addr(cfg_addr), .cfg_size(cfg_size),
        .cfg_enable(cfg_enable), .sts_addr(sts_addr), .sts_wraps(sts_wraps),
        .sts_overflow(sts_overflow), .sts_busy(sts_busy),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready)
    );

    axis_ring_writer #(.BURST_LEN(4), .FIFO_DEPTH(8)) dut_small (
        .aclk(aclk), .areset(areset), .cfg_addr(sm_cfg_addr), .cfg_size(sm_cfg_size),
        .cfg_enable(sm_cfg_enable), .sts_addr(sm_sts_addr), .sts_wraps(sm_sts_wraps),
        .sts_overflow(sm_sts_overflow), .sts_busy(sm_sts_busy),
        .m_axi_awid(sm_awid), .m_axi_awaddr(sm_awaddr), .m_axi_awlen(sm_awlen),
        .m_axi_awsize(sm_awsize), .m_axi_awburst(sm_awburst), .m_axi_awcache(sm_awcache),
        .m_axi_awvalid(sm_awvalid), .m_axi_awready(sm_awready), .m_axi_wid(sm_wid),
        .m_axi_wdata(sm_wdata), .m_axi_wstrb(sm_wstrb), .m_axi_wlast(sm_wlast),
        .m_axi_wvalid(sm_wvalid), .m_axi_wready(sm_wready),
        .m_axi_bvalid(sm_bvalid), .m_axi_bready(sm_bready),
        .s_axis_tdata(sm_tdata), .s_axis_tvalid(sm_tvalid), .s_axis_tready(sm_tready)
    );

    logic [31:0] aw_addr_q[$];
    logic [5:0]  aw_id_q[$];
    logic [3:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    logic        w_last_q[$];
    int          b_pend, feed_left, sm_left, sm_w_cnt, sm_acc;
    logic [63:0] feed_val, sm_val;
    bit          auto_b, m_hs, sm_hs;
    int          total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes mid-cycle, then update drivers just after the rising edge.
    task automatic cycle();
        @(negedge aclk);
        if (awvalid && awready) begin
            aw_addr_q.push_back(awaddr);
            aw_id_q.push_back(awid);
            aw_len_q.push_back(awlen);
            b_pend++;
        end
        if (wvalid && wready) begin
            w_data_q.push_back(wdata);
            w_last_q.push_back(wlast);
        end
        m_hs  = s_tvalid && s_tready;
        sm_hs = sm_tvalid && sm_tready;
        if (sm_wvalid && sm_wready) sm_w_cnt++;
        @(posedge aclk);
        #1;
        if (m_hs) begin feed_left--; feed_val++; end
        s_tvalid = (feed_left > 0);
        s_tdata  = feed_val;
        if (sm_hs) begin sm_left--; sm_val++; sm_acc++; end
        sm_tvalid = (sm_left > 0);
        sm_tdata  = sm_val;
        if (auto_b && b_pend > 0) begin bvalid = 1'b1; b_pend--; end
        else bvalid = 1'b0;
    endtask

    task automatic start_feed(input int n);
        feed_left = n;
        s_tvalid  = (n > 0);
        s_tdata   = feed_val;
    endtask

    initial begin
        int errs;
        total = 0; bad = 0; b_pend = 0; feed_left = 0; sm_left = 0;
        sm_w_cnt = 0; sm_acc = 0; feed_val = '0; sm_val = '0; auto_b = 1'b1;
        cfg_addr = 32'h1000_0000; cfg_size = 20'd64; cfg_enable = 1'b0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        sm_cfg_addr = '0; sm_cfg_size = 20'd8; sm_cfg_enable = 1'b0;
        sm_awready = 1'b1; sm_wready = 1'b1; sm_bvalid = 1'b0; sm_tvalid = 1'b0; sm_tdata = '0;

        repeat (3) cycle();
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_sts_addr", sts_addr, 0);
        chk("rst_wraps", sts_wraps, 0);
        chk("rst_overflow", sts_overflow, 0);
        chk("rst_busy", sts_busy, 0);
        chk("rst_tready", s_tready, 0);
        chk("const_awlen", awlen, 15);
        chk("const_awsize", awsize, 3);
        chk("const_awburst", awburst, 1);
        chk("const_awcache", awcache, 4'b0011);
        chk("const_wstrb", wstrb, 8'hff);
        chk("const_bready", bready, 1);
        areset = 1'b0;
        cycle();
        chk("tready_after_rst", s_tready, 1);

        // single burst
        cfg_enable = 1'b1;
        start_feed(16);
        for (int i = 0; i < 200 && w_data_q.size() < 16; i++) cycle();
        repeat (5) cycle();
        chk("t1_aw_count", aw_addr_q.size(), 1);
        chk("t1_awaddr", aw_addr_q[0], 32'h1000_0000);
        chk("t1_awid", aw_id_q[0], 0);
        chk("t1_awlen", aw_len_q[0], 15);
        chk("t1_beats", w_data_q.size(), 16);
        chk("t1_sts_addr", sts_addr, 16);

        // restart pointer, then five bursts across one wrap
        cfg_enable = 1'b0; repeat (2) cycle();
        cfg_enable = 1'b1; repeat (2) cycle();
        chk("t2_ptr_cleared", sts_addr, 0);
        start_feed(80);
        for (int i = 0; i < 1000 && w_data_q.size() < 96; i++) cycle();
        repeat (5) cycle();
        chk("t2_aw_count", aw_addr_q.size(), 6);
        chk("t2_aw1", aw_addr_q[1], 32'h1000_0000);
        chk("t2_aw2", aw_addr_q[2], 32'h1000_0080);
        chk("t2_aw3", aw_addr_q[3], 32'h1000_0100);
        chk("t2_aw4", aw_addr_q[4], 32'h1000_0180);
        chk("t2_aw5", aw_addr_q[5], 32'h1000_0000);
        chk("t2_id5", aw_id_q[5], 5);
        chk("t2_wraps", sts_wraps, 1);
        chk("t2_sts_addr", sts_addr, 16);
        errs = 0;
        for (int i = 0; i < 96 && i < w_data_q.size(); i++)
            if (w_data_q[i] !== 64'(i) || w_last_q[i] !== ((i % 16) == 15)) errs++;
        chk("t2_data_order", errs, 0);

        // AW held off: W completes first, no second burst until AW accepted
        awready = 1'b0;
        start_feed(32);
        for (int i = 0; i < 100 && w_data_q.size() < 112; i++) cycle();
        repeat (20) cycle();
        chk("t3_beats_held", w_data_q.size(), 112);
        chk("t3_awvalid", awvalid, 1);
        chk("t3_wvalid", wvalid, 0);
        chk("t3_busy", sts_busy, 1);
        chk("t3_aw_count", aw_addr_q.size(), 6);
        awready = 1'b1;
        for (int i = 0; i < 200 && w_data_q.size() < 128; i++) cycle();
        repeat (5) cycle();
        chk("t3_aw_after", aw_addr_q.size(), 8);
        chk("t3_aw6", aw_addr_q[6], 32'h1000_0080);
        chk("t3_aw7", aw_addr_q[7], 32'h1000_0100);
        chk("t3_sts_addr", sts_addr, 48);

        // response back-pressure limits outstanding bursts
        for (int i = 0; i < 50 && sts_busy; i++) cycle();
        chk("t4_idle", sts_busy, 0);
        auto_b = 1'b0;
        start_feed(128);
        repeat (300) cycle();
        chk("t4_aw_stall", aw_addr_q.size(), 12);
        chk("t4_busy", sts_busy, 1);
        chk("t4_awvalid", awvalid, 0);
        bvalid = 1'b1; b_pend--;
        cycle();
        for (int i = 0; i < 50 && aw_addr_q.size() < 13; i++) cycle();
        repeat (30) cycle();
        chk("t4_fifth_aw", aw_addr_q.size(), 13);
        auto_b = 1'b1;
        for (int i = 0; i < 1000 && w_data_q.size() < 256; i++) cycle();
        repeat (10) cycle();
        chk("t4_overflow", sts_overflow, 0);

        // small instance: wrap, then overflow with W stalled, then enable toggle clears
        sm_cfg_enable = 1'b1;
        sm_left = 12; sm_tvalid = 1'b1; sm_tdata = sm_val;
        for (int i = 0; i < 200 && sm_w_cnt < 12; i++) cycle();
        repeat (5) cycle();
        chk("t5_sm_addr", sm_sts_addr, 4);
        chk("t5_sm_wraps", sm_sts_wraps, 1);
        sm_wready = 1'b0;
        sm_left = 10; sm_tvalid = 1'b1; sm_tdata = sm_val;
        repeat (20) cycle();
        chk("t5_sm_accepted", sm_acc, 20);
        chk("t5_sm_tready", sm_tready, 0);
        chk("t5_sm_overflow", sm_sts_overflow, 1);
        sm_left = 0; sm_tvalid = 1'b0;
        sm_cfg_enable = 1'b0; cycle();
        sm_cfg_enable = 1'b1; cycle();
        chk("t5_ovf_cleared", sm_sts_overflow, 0);
        chk("t5_addr_cleared", sm_sts_addr, 0);
        chk("t5_wraps_cleared", sm_sts_wraps, 0);

        // reset mid-burst during beat 7
        start_feed(16);
        for (int i = 0; i < 200 && w_data_q.size() < 263; i++) cycle();
        chk("t6_in_burst", wvalid, 1);
        feed_left = 0; s_tvalid = 1'b0;
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        #1;
        chk("t6_awvalid", awvalid, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_sts_addr", sts_addr, 0);
        chk("t6_busy", sts_busy, 0);
        chk("t6_tready", s_tready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
